// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input
// in timebase units of N clock_in cycles (N = 1, or 2*(division_value+1)).
// Measurements run back-to-back; the rise closing one period opens the next.
module pwm_capture #(
  parameter int W = 16
) (
  input  logic         clock_in,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [7:0]   division_value,
  input  logic         clear_ovf,
  input  logic         pwm_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         overflow,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           sync1_q, sync2_q, prev_q;
  logic [7:0]     div_q;
  logic [8:0]     pre_q, pre_d;      // cycles into the current period unit
  logic [W-1:0]   per_q, per_d;      // whole period units so far
  logic [8:0]     hpre_q, hpre_d;    // high cycles into the current high unit
  logic [W-1:0]   hi_q, hi_d;        // whole high units so far
  logic [W-1:0]   period_q, period_d;
  logic [W-1:0]   high_q, high_d;
  logic           valid_q, valid_d;
  logic           ovf_q;
  logic           busy_q;

  logic           rise_s;
  logic           div_chg_s;
  logic [8:0]     nm1_s;             // N-1, prescaler terminal count
  logic [8:0]     first_pre_s;       // prescaler after counting the rise cycle
  logic [W-1:0]   first_unit_s;      // unit count after counting the rise cycle
  logic           per_tick_s;
  logic           hi_tick_s;
  logic           set_ovf_s;

  assign rise_s       = sync2_q & ~prev_q;
  assign div_chg_s    = (division_value != div_q);
  assign nm1_s        = (div_q == 8'd0) ? 9'd0 : {div_q, 1'b1};
  assign first_pre_s  = (nm1_s == 9'd0) ? 9'd0 : 9'd1;
  assign first_unit_s = (nm1_s == 9'd0) ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
  assign per_tick_s   = (pre_q == nm1_s);
  assign hi_tick_s    = (hpre_q == nm1_s);

  // Next-state, counter and result computation; counters default to cleared.
  always_comb begin
    state_d   = state_q;
    pre_d     = 9'd0;
    per_d     = {W{1'b0}};
    hpre_d    = 9'd0;
    hi_d      = {W{1'b0}};
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    set_ovf_s = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else if (div_chg_s) begin
      // timebase changed under us: the running measurement is meaningless
      state_d = ARM;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          if (rise_s) begin
            state_d = MEASURE;
            pre_d   = first_pre_s;
            per_d   = first_unit_s;
            hpre_d  = first_pre_s;
            hi_d    = first_unit_s;
          end else begin
            state_d = ARM;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            // close this period and open the next one on the same edge
            valid_d  = 1'b1;
            period_d = per_q;
            high_d   = hi_q;
            pre_d    = first_pre_s;
            per_d    = first_unit_s;
            hpre_d   = first_pre_s;
            hi_d     = first_unit_s;
          end else if (per_tick_s && (per_q == {W{1'b1}})) begin
            set_ovf_s = 1'b1;
            state_d   = ARM;
          end else begin
            pre_d = per_tick_s ? 9'd0 : pre_q + 9'd1;
            per_d = per_q + {{(W-1){1'b0}}, per_tick_s};
            if (sync2_q) begin
              hpre_d = hi_tick_s ? 9'd0 : hpre_q + 9'd1;
              hi_d   = hi_q + {{(W-1){1'b0}}, hi_tick_s};
            end else begin
              hpre_d = hpre_q;
              hi_d   = hi_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, synchronizer, counters and registered outputs.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      div_q    <= 8'd0;
      pre_q    <= 9'd0;
      per_q    <= {W{1'b0}};
      hpre_q   <= 9'd0;
      hi_q     <= {W{1'b0}};
      period_q <= {W{1'b0}};
      high_q   <= {W{1'b0}};
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= pwm_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      div_q    <= division_value;
      pre_q    <= pre_d;
      per_q    <= per_d;
      hpre_q   <= hpre_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d == MEASURE);
      if (set_ovf_s) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf || !enable) begin
        ovf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q;
      end
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a waveform generator drives pwm_in and a
// reference model measures synchronized rise-to-rise intervals arithmetically.
module tb_pwm_capture;
  localparam int W = 8;
  localparam int MAXU = (1 << W) - 1;

  logic         clock_in = 1'b0;
  logic         reset_n = 1'b1;
  logic         enable = 1'b0;
  logic [7:0]   division_value = 8'd0;
  logic         clear_ovf = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic         valid, overflow, busy;

  pwm_capture #(.W(W)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .enable(enable),
    .division_value(division_value), .clear_ovf(clear_ovf), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .valid(valid),
    .overflow(overflow), .busy(busy)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: mode 0 off, 1 waiting for first rise, 2 measuring
  int cyc = 0, t0 = 0, hc = 0, mode = 0, divp = 0, m_per = 0, m_hi = 0;
  bit h1, h2, h3, m_ovf, m_valid;

  // waveform generator
  int wa_p = 10, wa_h = 3, wb_p = 10, wb_h = 3, ph = -1;
  bit use_b = 0, alt = 0, wave_on = 0, level = 0;

  task automatic model_update();
    int n;
    bit s, rise, set;
    cyc++;
    if (!reset_n) begin
      h1 = 0; h2 = 0; h3 = 0; mode = 0; divp = 0;
      m_ovf = 0; m_valid = 0; m_per = 0; m_hi = 0;
      return;
    end
    s = h2;
    rise = h2 & !h3;
    n = (divp == 0) ? 1 : 2 * (divp + 1);
    set = 0;
    m_valid = 0;
    if (!enable) mode = 0;
    else if (int'(division_value) != divp) mode = 1;
    else if (mode == 0) mode = 1;
    else if (rise) begin
      if (mode == 2) begin
        m_per = (cyc - t0) / n;
        m_hi = hc / n;
        m_valid = 1;
      end
      t0 = cyc; hc = 1; mode = 2;
    end else if (mode == 2) begin
      hc += int'(s);
      if ((cyc - t0 + 1) / n > MAXU) begin
        set = 1; mode = 1;
      end
    end
    if (set) m_ovf = 1;
    else if (clear_ovf || !enable) m_ovf = 0;
    divp = int'(division_value);
    h3 = h2; h2 = h1; h1 = pwm_in;
  endtask

  task automatic wave_next();
    int cp, ch;
    if (wave_on) begin
      ph++;
      cp = use_b ? wb_p : wa_p;
      if (ph >= cp) begin
        ph = 0;
        if (alt) use_b = !use_b;
      end
      ch = use_b ? wb_h : wa_h;
      pwm_in = (ph < ch);
    end else begin
      pwm_in = level;
    end
  endtask

  task automatic set_wave(input int pa, input int ha, input int pb, input int hb, input bit a);
    wa_p = pa; wa_h = ha; wb_p = pb; wb_h = hb; alt = a;
    ph = -1; use_b = 0; wave_on = 1;
  endtask

  task automatic step();
    @(posedge clock_in);
    model_update();
    #1;
    check_eq("valid", valid, m_valid);
    check_eq("busy", busy, mode == 2);
    check_eq("overflow", overflow, m_ovf);
    check_eq("period", period, m_per);
    check_eq("high_time", high_time, m_hi);
    wave_next();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k, p, h;
    #1 reset_n = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(2);

    // basic N=1, 10/3
    set_wave(10, 3, 10, 3, 0);
    enable = 1'b1;
    run(60);
    check_eq("basic_period", period, 10);
    check_eq("basic_high", high_time, 3);
    check_eq("basic_busy", busy, 1);

    // timebase change mid-measure, then N=4 with 40/10
    set_wave(40, 10, 40, 10, 0);
    run(25);
    division_value = 8'd1;
    run(200);
    check_eq("n4_period", period, 10);
    check_eq("n4_high", high_time, 2);

    // N=512 with 2048/700
    division_value = 8'd255;
    set_wave(2048, 700, 2048, 700, 0);
    run(6500);
    check_eq("n512_period", period, 4);
    check_eq("n512_high", high_time, 1);

    // overflow: one pulse then constant low
    division_value = 8'd0;
    wave_on = 0; level = 0;
    run(5);
    level = 1;
    run(3);
    level = 0;
    run(300);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_busy", busy, 0);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check_eq("ovf_clear", overflow, 0);
    set_wave(10, 3, 10, 3, 0);
    run(40);
    check_eq("resume_period", period, 10);

    // back-to-back alternating periods
    set_wave(12, 4, 20, 15, 1);
    run(200);

    // enable drop mid-measure
    k = 0;
    while (!busy && k < 100) begin step(); k++; end
    check_eq("busy_wait", busy, 1);
    run(5);
    enable = 1'b0;
    step();
    check_eq("dis_busy", busy, 0);
    enable = 1'b1;
    run(60);

    // asynchronous reset mid-measure
    k = 0;
    while (!busy && k < 100) begin step(); k++; end
    check_eq("busy_wait2", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_period", period, 0);
    check_eq("rst_high", high_time, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", valid, 0);
    run(2);
    reset_n = 1'b1;
    run(60);

    // randomized segments
    for (int seg = 0; seg < 30; seg++) begin
      enable = ($urandom_range(0, 7) != 0);
      clear_ovf = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        division_value = 8'd0;
        wave_on = 0;
        level = $urandom_range(0, 1);
        step();
        clear_ovf = 1'b0;
        run(400);
      end else begin
        division_value = 8'($urandom_range(0, 3));
        p = $urandom_range(2, 40);
        h = $urandom_range(1, p - 1);
        k = $urandom_range(2, 40);
        set_wave(p, h, k, $urandom_range(1, k - 1), $urandom_range(0, 1) == 1);
        step();
        clear_ovf = 1'b0;
        run($urandom_range(50, 300));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM capture/measurement block, the receive-side counterpart to the PWM generator and its clock divider.
- Samples an external PWM input and measures its period and high time.
- Results are expressed in the same timebase units the generator uses: one unit = N clock_in cycles, where N = 1 if division_value == 0, else 2*(division_value+1).
- Results feed a register interface or control logic.

Parameters:
- W, 16: width of the period/high_time counters and result outputs.

Ports:
- clock_in       input   1  system clock.
- reset_n        input   1  asynchronous, active-low reset.
- enable         input   1  1 = capture running; 0 = idle.
- division_value input   8  timebase select; N as defined above.
- clear_ovf      input   1  1-cycle pulse; clears overflow.
- pwm_in         input   1  asynchronous PWM input.
- period         output  W  last measured period, in units.
- high_time      output  W  last measured high time, in units.
- valid          output  1  1-cycle pulse when period/high_time update.
- overflow       output  1  sticky; a period exceeded the counter range.
- busy           output  1  1 while state == MEASURE.

Behaviour:
- Reset:
  - reset_n low asynchronously clears all registers: synchronizer, counters, state=IDLE, period=0, high_time=0, valid=0, overflow=0, busy=0.
  - Reset mid-measurement discards the in-flight measurement.
- Input conditioning:
  - 2-flop synchronizer (reset 0) produces pwm_s; prev flop (reset 0) follows it.
  - rise = pwm_s & ~prev.
  - A pwm_in rising edge is seen as rise 2–3 clock_in cycles later.
- Prescaler:
  - 9-bit counter; tick asserted every N cycles (N up to 512).
  - Counter restarts its phase on every rise, so units align to the rising edge.
  - division_value is registered internally. Any change vs. the registered copy aborts the current measurement: MEASURE -> ARM, no valid, counters cleared.
- State machine:
  - IDLE:
    - Entered whenever enable=0 (from any state, same cycle).
    - Counters cleared; period/high_time hold last values; busy=0.
    - enable=1 -> ARM.
  - ARM:
    - Wait for rise.
    - rise -> MEASURE; period counter and high counter start from this cycle.
  - MEASURE (busy=1):
    - Period counter advances one unit per N cycles.
    - High counter advances only for cycles where pwm_s=1.
    - Next rise:
      - period <= floor(P/N) and high_time <= floor(H/N).
      - P = clock_in cycles between the two synchronized rises; H = cycles with pwm_s=1 in that interval.
      - valid=1 for exactly one cycle (the cycle after the rise).
      - Counters restart immediately; the closing rise opens the next period, so no edge is lost and measurements are back-to-back.
    - Period counter would exceed 2^W-1 before a rise:
      - overflow <= 1; no valid; -> ARM.
- Outputs:
  - First valid after enable requires two rises.
  - period/high_time are registered and change only together with valid.
  - high_time <= period always holds.
- overflow:
  - Set as above.
  - Cleared by clear_ovf or enable=0.
  - If set and clear_ovf occur in the same cycle, set wins.
- Degenerate input:
  - Constant-level input produces no valid; overflow is set once a rise has been seen and the range is exceeded.
  - A single high clock_in cycle shorter than the synchronizer can resolve may be missed; this is not an error.

Test Plan:
- Basic, N=1: enable=1, division_value=0, pwm_in period 10 cycles / high 3 cycles.
  - valid pulses every 10 cycles starting after the 2nd rise.
  - period=10, high_time=3, busy=1.
- Prescaled, N=4: division_value=1, period 40 cycles / high 10 cycles.
  - period=10, high_time=2 (floor(10/4)).
  - division_value=255 with period 2048 cycles -> period=4.
- Overflow: W=8, division_value=0, one pulse then constant low.
  - overflow=1 within 256 cycles after the rise; no valid; state returns to ARM.
  - clear_ovf pulse -> overflow=0.
  - Resume 10/3 PWM -> valid with period=10 after two rises.
- division_value change: change 0->1 mid-MEASURE.
  - No valid for the interrupted period.
  - Next valid reports N=4 units, after two further rises.
- Reset/enable:
  - reset_n low mid-MEASURE -> period=0, high_time=0, busy=0 immediately (asynchronous).
  - enable=0 mid-MEASURE -> busy=0 next cycle; period/high_time keep last values; no valid.
- Back-to-back: alternate periods 12/4 and 20/15 cycles (N=1).
  - Each rise yields valid with the matching values, in order, with no missed period.
